// File: rtl/adder_axil_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_axil_pkg                                                       |
// | Register map, STATUS/CTRL bit positions and AXI response codes.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_axil_pkg;

  localparam logic [3:0] ADDR_OP_A   = 4'h0;
  localparam logic [3:0] ADDR_OP_B   = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_RESULT = 4'hC;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_CARRY = 2;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  // Word index of a byte address; the low two bits never select anything.
  function automatic logic [1:0] reg_idx(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_axil_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_axil_if                                                        |
// | AXI4-Lite bundle for the adder register block.                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface adder_axil_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                              wvalid;
  logic                              wready;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_pipe                                                           |
// | LAT-stage registered add with carry-out and a matching valid chain.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [WIDTH:0]   o_sum
);
  logic [LAT-1:0] r_vld;
  logic [WIDTH:0] r_sum [LAT];

  // Sum is formed in the first stage; later stages only delay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_sum[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_sum[0] <= {1'b0, i_a} + {1'b0, i_b};
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_sum[i] <= r_sum[i-1];
      end
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_sum   = r_sum[LAT-1];
endmodule
`default_nettype wire

// File: rtl/adder_axil_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_axil_slave                                                     |
// | AXI4-Lite register block: operands, START/CLR control, result/status.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_axil_slave
  import adder_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADD_LAT            = 2
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  adder_axil_if.slave s_axi,
  output logic        done_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic          r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [1:0]    r_aw_idx;
  logic [DW-1:0] r_w_data, r_rdata, r_op_a, r_op_b, r_result;
  logic [SW-1:0] r_w_strb;
  logic          r_busy, r_done, r_carry;

  logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic          w_ctrl_wr, w_start, w_clr;
  logic          w_pipe_valid;
  logic [DW:0]   w_pipe_sum;
  logic [DW-1:0] w_status, w_rd_data;
  logic          w_unused;

  assign w_aw_hs   = s_axi.awvalid && !r_aw_held;
  assign w_w_hs    = s_axi.wvalid && !r_w_held;
  assign w_ar_hs   = s_axi.arvalid && !r_rvalid;
  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;
  assign w_ctrl_wr = w_commit && (r_aw_idx == reg_idx(ADDR_CTRL));
  assign w_start   = w_ctrl_wr && r_w_strb[0] && r_w_data[CTRL_START] && !r_busy;
  assign w_clr     = w_ctrl_wr && r_w_data[CTRL_CLR_DONE];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_commit) r_aw_held <= 1'b0;
      else if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= reg_idx(s_axi.awaddr[3:0]);
      end
      if (w_commit) r_w_held <= 1'b0;
      else if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi.wdata;
        r_w_strb <= s_axi.wstrb;
      end
      if (w_commit) r_bvalid <= 1'b1;
      else if (s_axi.bready) r_bvalid <= 1'b0;
      // Captured from pre-edge state, so a same-edge commit is not visible.
      if (w_ar_hs) begin
        r_rdata  <= w_rd_data;
        r_rvalid <= 1'b1;
      end else if (s_axi.rready) r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < SW; i++) begin
        if (r_w_strb[i] && r_aw_idx == reg_idx(ADDR_OP_A)) r_op_a[8*i +: 8] <= r_w_data[8*i +: 8];
        if (r_w_strb[i] && r_aw_idx == reg_idx(ADDR_OP_B)) r_op_b[8*i +: 8] <= r_w_data[8*i +: 8];
      end
    end
  end

  // Completion outranks a coincident CLR_DONE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_pipe_valid) begin
      r_result <= w_pipe_sum[DW-1:0];
      r_carry  <= w_pipe_sum[DW];
      r_busy   <= 1'b0;
      r_done   <= 1'b1;
    end else if (w_start) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (w_clr) begin
      r_done <= 1'b0;
    end
  end

  adder_pipe #(.WIDTH(DW), .LAT(ADD_LAT)) u_pipe (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .i_valid (w_start),
    .i_a     (r_op_a),
    .i_b     (r_op_b),
    .o_valid (w_pipe_valid),
    .o_sum   (w_pipe_sum)
  );

  always_comb begin
    w_status           = '0;
    w_status[ST_BUSY]  = r_busy;
    w_status[ST_DONE]  = r_done;
    w_status[ST_CARRY] = r_carry;
  end

  always_comb begin
    w_rd_data = '0;
    case (reg_idx(s_axi.araddr[3:0]))
      reg_idx(ADDR_OP_A): w_rd_data = r_op_a;
      reg_idx(ADDR_OP_B): w_rd_data = r_op_b;
      reg_idx(ADDR_CTRL): w_rd_data = w_status;
      default:            w_rd_data = r_result;
    endcase
  end

  assign s_axi.awready = !r_aw_held;
  assign s_axi.wready  = !r_w_held;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.arready = !r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.rvalid  = r_rvalid;
  assign done_o        = r_done;

  assign w_unused = ^{s_axi.awaddr[1:0], s_axi.awprot, s_axi.araddr[1:0], s_axi.arprot};
endmodule
`default_nettype wire

// File: tb/tb_adder_axil_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_adder_axil_slave                                                  |
// | Directed AXI-Lite bench with a read-data scoreboard.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_adder_axil_slave;
  localparam int ADD_LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic done;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  adder_axil_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  adder_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .ADD_LAT            (ADD_LAT)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .s_axi   (bus),
    .done_o  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 0, w_done = 0, b_seen = 0, aw_hs, w_hs;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; bus.wvalid  = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int n = 0; n < 20 && !b_seen; n++) begin
      if (bus.bvalid && bus.bready) begin
        b_seen = 1;
        check("bresp", {30'b0, bus.bresp}, 32'h0);
      end
      tick();
    end
    n_checks++;
    assert (aw_done && w_done && b_seen) else begin
      n_err++;
      $error("FAIL write_timeout: observed=%0b%0b%0b expected=111", aw_done, w_done, b_seen);
    end
  endtask

  task automatic axi_read_raw(input logic [3:0] addr, output logic [31:0] data, output bit ok);
    bit ar_done = 0, r_seen = 0, hs;
    data = 'x;
    bus.araddr = addr; bus.arvalid = 1'b1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      hs = bus.arready;
      tick();
      if (hs) ar_done = 1;
    end
    bus.arvalid = 1'b0;
    for (int n = 0; n < 20 && !r_seen; n++) begin
      if (bus.rvalid && bus.rready) begin r_seen = 1; data = bus.rdata; end
      tick();
    end
    ok = ar_done && r_seen;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d, e;
    string t;
    bit ok;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    axi_read_raw(addr, d, ok);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (ok) check(t, d, e);
    else begin
      n_checks++;
      assert (ok) else begin
        n_err++;
        $error("FAIL %s_timeout: observed=no_response expected=response", t);
      end
    end
  endtask

  // Back-to-back AW+W issue: handshake on the first edge, commit on the second.
  task automatic issue(input logic [3:0] addr, input logic [31:0] data);
    check("issue_ready", {30'b0, bus.awready, bus.wready}, 32'h3);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    bit ok;
    int polls, n_hold, n_b;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 1;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
    check("rst_valid", {30'b0, bus.bvalid, bus.rvalid}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    axi_read(4'hC, 32'h0, "rst_result");

    // Basic add with BUSY poll.
    axi_write(4'h0, 32'h3, 4'hF);
    axi_write(4'h4, 32'h5, 4'hF);
    axi_write(4'h8, 32'h1, 4'hF);
    axi_read_raw(4'h8, d, ok);
    check("t1_status_busy", d, 32'h1);
    polls = 0;
    while (d[0] === 1'b1 && polls < 20) begin
      axi_read_raw(4'h8, d, ok);
      polls++;
    end
    check("t1_poll_ok", {31'b0, ok}, 32'h1);
    check("t1_status_done", d, 32'h2);
    check("t1_done_o", {31'b0, done}, 32'h1);
    axi_read(4'hC, 32'h8, "t1_result");

    // Wrap-around with carry.
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    axi_write(4'h8, 32'h1, 4'hF);
    repeat (ADD_LAT + 2) tick();
    axi_read(4'h8, 32'h6, "t2_status");
    axi_read(4'hC, 32'h0, "t2_result");

    // W before AW, then AW before W, with B back-pressure.
    bus.bready = 1'b0;
    bus.wdata = 32'hC0FF_EE01; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    repeat (3) tick();
    check("t3_no_b_before_aw", {31'b0, bus.bvalid}, 32'h0);
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    tick();
    check("t3_b_first", {31'b0, bus.bvalid}, 32'h1);
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    tick();
    check("t3_aw_stalled", {31'b0, bus.awready}, 32'h0);
    bus.wdata = 32'hBEEF_0002; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    n_hold = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.bvalid) n_hold++;
      tick();
    end
    check("t3_b_held", n_hold, 32'd4);
    check("t3_bresp", {30'b0, bus.bresp}, 32'h0);
    bus.bready = 1'b1;
    n_b = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.bvalid) n_b++;
      tick();
    end
    check("t3_b_count", n_b, 32'd2);
    axi_read(4'h0, 32'hC0FF_EE01, "t3_op_a");
    axi_read(4'h4, 32'hBEEF_0002, "t3_op_b");

    // Byte strobes and read-only RESULT.
    axi_write(4'h0, 32'hAAAA_AAAA, 4'hF);
    axi_write(4'h0, 32'h1234_5678, 4'b0011);
    axi_read(4'h0, 32'hAAAA_5678, "t4_strb");
    axi_write(4'hC, 32'h0000_DEAD, 4'hF);
    axi_read(4'hC, 32'h0, "t4_result_ro");

    // Operand write and re-START while busy; sum must use the first operands.
    axi_write(4'h0, 32'd10, 4'hF);
    axi_write(4'h4, 32'd20, 4'hF);
    issue(4'h8, 32'h1);
    issue(4'h0, 32'd100);
    issue(4'h8, 32'h1);
    repeat (ADD_LAT + 6) tick();
    axi_read(4'hC, 32'd30, "t5_result_first");
    axi_read(4'h8, 32'h2, "t5_status");
    axi_read(4'h0, 32'd100, "t5_op_a");

    // CLR_DONE landing on the completion edge.
    issue(4'h8, 32'h1);
    issue(4'h4, 32'd1);
    issue(4'h8, 32'h2);
    check("t5_done_wins", {31'b0, done}, 32'h1);
    axi_read(4'h8, 32'h2, "t5_status_clr");
    axi_read(4'hC, 32'd120, "t5_result_second");
    axi_write(4'h8, 32'h2, 4'hF);
    axi_read(4'h8, 32'h0, "t5_clr_done");

    // Asynchronous reset with B and R pending and an add in flight.
    axi_write(4'h0, 32'd7, 4'hF);
    axi_write(4'h4, 32'd9, 4'hF);
    bus.bready = 1'b0;
    issue(4'h8, 32'h1);
    bus.rready = 1'b0;
    bus.araddr = 4'h0; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    tick();
    check("t6_pending", {30'b0, bus.bvalid, bus.rvalid}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {30'b0, bus.bvalid, bus.rvalid}, 32'h0);
    check("t6_rst_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
    check("t6_rst_rdata", bus.rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    repeat (ADD_LAT + 4) tick();
    check("t6_done_lost", {31'b0, done}, 32'h0);
    axi_read(4'h0, 32'h0, "t6_op_a");
    axi_read(4'h4, 32'h0, "t6_op_b");
    axi_read(4'h8, 32'h0, "t6_status");
    axi_read(4'hC, 32'h0, "t6_result");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
